// File: rtl/register_bank_scoreboard.sv
// Two-read / one-write register bank with an optional hard-wired zero
// register, optional same-cycle write-to-read forwarding, and a per-register
// pending-write scoreboard. Decode reads registers and reserves destinations;
// writeback writes results and releases them.
module register_bank_scoreboard #(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 5,
    parameter int DEPTH          = 32,
    parameter int ZERO_REG_EN    = 1,
    parameter int ZERO_REG_INDEX = 31,
    parameter int BYPASS_EN      = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] read_address_1,
    input  logic [ADDR_WIDTH-1:0] read_address_2,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic [DATA_WIDTH-1:0] read_data_2,
    output logic                  busy_1,
    output logic                  busy_2,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  reserve,
    input  logic [ADDR_WIDTH-1:0] reserve_address,
    output logic [ADDR_WIDTH:0]   pending_count
);

    // Index width into the storage; addresses are range-checked before the
    // upper bits are dropped, so out-of-range addresses never alias.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ZERO_L  = ADDR_WIDTH'(ZERO_REG_INDEX);

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      pending;
    logic [DEPTH-1:0]      pending_next;

    logic                  write_ok;
    logic                  reserve_ok;
    logic [IDX_W-1:0]      write_idx;
    logic [IDX_W-1:0]      reserve_idx;
    logic                  count_gain;
    logic                  count_loss;

    logic [1:0][ADDR_WIDTH-1:0] rd_addr;
    logic [1:0][DATA_WIDTH-1:0] rd_data;
    logic [1:0]                 rd_busy;

    // An address is usable when it names an implemented register that is
    // not the hard-wired zero register.
    function automatic logic usable(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} < DEPTH_L) && !((ZERO_REG_EN != 0) && (a == ZERO_L));
    endfunction

    assign write_ok    = write && usable(write_address);
    assign reserve_ok  = reserve && usable(reserve_address);
    assign write_idx   = write_address[IDX_W-1:0];
    assign reserve_idx = reserve_address[IDX_W-1:0];

    // A reserve always counts when the bit was clear; a write only counts as
    // a release when it is not immediately re-reserved by the same cycle.
    assign count_gain = reserve_ok && !pending[reserve_idx];
    assign count_loss = write_ok && pending[write_idx] &&
                        !(reserve_ok && (reserve_address == write_address));

    // Register storage: cleared asynchronously, written by writeback.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (write_ok) begin
            regs[write_idx] <= write_data;
        end
    end

    // Next scoreboard: release first, then reserve, so a new producer wins.
    always_comb begin
        pending_next = pending;
        if (write_ok) begin
            pending_next[write_idx] = 1'b0;
        end
        if (reserve_ok) begin
            pending_next[reserve_idx] = 1'b1;
        end
    end

    // Scoreboard bits and their running population count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending       <= '0;
            pending_count <= '0;
        end else begin
            pending       <= pending_next;
            pending_count <= pending_count + (ADDR_WIDTH + 1)'(count_gain)
                                           - (ADDR_WIDTH + 1)'(count_loss);
        end
    end

    assign rd_addr[0] = read_address_1;
    assign rd_addr[1] = read_address_2;

    // Combinational read ports with zero-register, range, bypass and reset masking.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < 2; p++) begin
            if (!reset && usable(rd_addr[p])) begin
                if ((BYPASS_EN != 0) && write_ok && (write_address == rd_addr[p])) begin
                    rd_data[p] = write_data;
                end else begin
                    rd_data[p] = regs[rd_addr[p][IDX_W-1:0]];
                    rd_busy[p] = pending[rd_addr[p][IDX_W-1:0]];
                end
            end
        end
    end

    assign read_data_1 = rd_data[0];
    assign read_data_2 = rd_data[1];
    assign busy_1      = rd_busy[0];
    assign busy_2      = rd_busy[1];

endmodule

// File: tb/tb_register_bank_scoreboard.sv
// Directed bench for register_bank_scoreboard: default configuration, a
// non-bypassing copy and a narrow/shallow copy, all sharing clock and reset.
module tb_register_bank_scoreboard;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    // Default configuration (bypass on)
    logic [4:0]  a_ra1 = '0, a_ra2 = '0, a_wa = '0, a_rsa = '0;
    logic [63:0] a_wd = '0;
    logic        a_w = 1'b0, a_rs = 1'b0;
    logic [63:0] a_rd1, a_rd2;
    logic        a_b1, a_b2;
    logic [5:0]  a_pc;

    // Bypass disabled
    logic [4:0]  b_ra1 = '0, b_ra2 = '0, b_wa = '0, b_rsa = '0;
    logic [63:0] b_wd = '0;
    logic        b_w = 1'b0, b_rs = 1'b0;
    logic [63:0] b_rd1, b_rd2;
    logic        b_b1, b_b2;
    logic [5:0]  b_pc;

    // 32-bit data, 16 registers, 5-bit addresses
    logic [4:0]  c_ra1 = '0, c_ra2 = '0, c_wa = '0, c_rsa = '0;
    logic [31:0] c_wd = '0;
    logic        c_w = 1'b0, c_rs = 1'b0;
    logic [31:0] c_rd1, c_rd2;
    logic        c_b1, c_b2;
    logic [5:0]  c_pc;

    register_bank_scoreboard dut_a (
        .clock(clock), .reset(reset),
        .read_address_1(a_ra1), .read_address_2(a_ra2),
        .read_data_1(a_rd1), .read_data_2(a_rd2),
        .busy_1(a_b1), .busy_2(a_b2),
        .write(a_w), .write_address(a_wa), .write_data(a_wd),
        .reserve(a_rs), .reserve_address(a_rsa),
        .pending_count(a_pc)
    );

    register_bank_scoreboard #(.BYPASS_EN(0)) dut_b (
        .clock(clock), .reset(reset),
        .read_address_1(b_ra1), .read_address_2(b_ra2),
        .read_data_1(b_rd1), .read_data_2(b_rd2),
        .busy_1(b_b1), .busy_2(b_b2),
        .write(b_w), .write_address(b_wa), .write_data(b_wd),
        .reserve(b_rs), .reserve_address(b_rsa),
        .pending_count(b_pc)
    );

    register_bank_scoreboard #(.DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(5)) dut_c (
        .clock(clock), .reset(reset),
        .read_address_1(c_ra1), .read_address_2(c_ra2),
        .read_data_1(c_rd1), .read_data_2(c_rd2),
        .busy_1(c_b1), .busy_2(c_b2),
        .write(c_w), .write_address(c_wa), .write_data(c_wd),
        .reserve(c_rs), .reserve_address(c_rsa),
        .pending_count(c_pc)
    );

    // Free-running clock, period 10
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        a_w = 1'b1; a_wa = 5'd9; a_wd = 64'hFF; a_ra1 = 5'd9;
        a_rs = 1'b1; a_rsa = 5'd9;
        #1;
        checks++; if (a_rd1 !== 64'h0) begin failures++; $display("[TB] FAIL reset_no_forward got=%h exp=%h", a_rd1, 64'h0); end
        checks++; if (a_b1 !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", a_b1); end
        tick;
        tick;
        reset = 1'b0; a_w = 1'b0; a_rs = 1'b0;
        #1;
        checks++; if (a_pc !== 6'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", a_pc); end
        for (int i = 0; i < 32; i++) begin
            a_ra1 = 5'(i);
            a_ra2 = 5'(31 - i);
            #1;
            checks++; if (a_rd1 !== 64'h0) begin failures++; $display("[TB] FAIL reset_rd1[%0d] got=%h exp=0", i, a_rd1); end
            checks++; if (a_rd2 !== 64'h0) begin failures++; $display("[TB] FAIL reset_rd2[%0d] got=%h exp=0", 31 - i, a_rd2); end
            checks++; if (a_b1 !== 1'b0) begin failures++; $display("[TB] FAIL reset_b1[%0d] got=%b exp=0", i, a_b1); end
            checks++; if (a_b2 !== 1'b0) begin failures++; $display("[TB] FAIL reset_b2[%0d] got=%b exp=0", 31 - i, a_b2); end
        end
    endtask

    task automatic test_write;
        a_w = 1'b1; a_wa = 5'd5; a_wd = 64'hDEADBEEF_CAFEF00D;
        tick;
        a_w = 1'b0; a_ra1 = 5'd5; a_ra2 = 5'd5;
        #1;
        checks++; if (a_rd1 !== 64'hDEADBEEF_CAFEF00D) begin failures++; $display("[TB] FAIL write_rd1 got=%h exp=%h", a_rd1, 64'hDEADBEEF_CAFEF00D); end
        checks++; if (a_rd2 !== 64'hDEADBEEF_CAFEF00D) begin failures++; $display("[TB] FAIL write_rd2 got=%h exp=%h", a_rd2, 64'hDEADBEEF_CAFEF00D); end
    endtask

    task automatic test_zero_reg;
        a_w = 1'b1; a_wa = 5'd31; a_wd = 64'h1234;
        tick;
        a_w = 1'b0; a_ra1 = 5'd31; a_ra2 = 5'd31;
        #1;
        checks++; if (a_rd1 !== 64'h0) begin failures++; $display("[TB] FAIL zero_rd1 got=%h exp=0", a_rd1); end
        checks++; if (a_rd2 !== 64'h0) begin failures++; $display("[TB] FAIL zero_rd2 got=%h exp=0", a_rd2); end
        a_rs = 1'b1; a_rsa = 5'd31;
        tick;
        a_rs = 1'b0;
        #1;
        checks++; if (a_b1 !== 1'b0) begin failures++; $display("[TB] FAIL zero_busy got=%b exp=0", a_b1); end
        checks++; if (a_pc !== 6'd0) begin failures++; $display("[TB] FAIL zero_count got=%0d exp=0", a_pc); end
    endtask

    task automatic test_bypass;
        a_w = 1'b1; a_wa = 5'd7; a_wd = 64'hAA;
        b_w = 1'b1; b_wa = 5'd7; b_wd = 64'hAA;
        tick;
        a_wd = 64'h55; a_ra2 = 5'd7;
        b_wd = 64'h55; b_ra2 = 5'd7;
        #1;
        checks++; if (a_rd2 !== 64'h55) begin failures++; $display("[TB] FAIL bypass_on_rd2 got=%h exp=%h", a_rd2, 64'h55); end
        checks++; if (a_b2 !== 1'b0) begin failures++; $display("[TB] FAIL bypass_on_busy got=%b exp=0", a_b2); end
        checks++; if (b_rd2 !== 64'hAA) begin failures++; $display("[TB] FAIL bypass_off_same got=%h exp=%h", b_rd2, 64'hAA); end
        tick;
        a_w = 1'b0; b_w = 1'b0;
        #1;
        checks++; if (b_rd2 !== 64'h55) begin failures++; $display("[TB] FAIL bypass_off_next got=%h exp=%h", b_rd2, 64'h55); end
        checks++; if (a_rd2 !== 64'h55) begin failures++; $display("[TB] FAIL bypass_on_next got=%h exp=%h", a_rd2, 64'h55); end
    endtask

    task automatic test_scoreboard;
        a_rs = 1'b1; a_rsa = 5'd3;
        tick;
        a_rs = 1'b0; a_ra1 = 5'd3; a_ra2 = 5'd3;
        #1;
        checks++; if (a_b1 !== 1'b1) begin failures++; $display("[TB] FAIL sb_reserve_b1 got=%b exp=1", a_b1); end
        checks++; if (a_b2 !== 1'b1) begin failures++; $display("[TB] FAIL sb_reserve_b2 got=%b exp=1", a_b2); end
        checks++; if (a_pc !== 6'd1) begin failures++; $display("[TB] FAIL sb_reserve_count got=%0d exp=1", a_pc); end
        a_w = 1'b1; a_wa = 5'd3; a_wd = 64'h33;
        #1;
        checks++; if (a_b1 !== 1'b0) begin failures++; $display("[TB] FAIL sb_forward_busy got=%b exp=0", a_b1); end
        checks++; if (a_rd1 !== 64'h33) begin failures++; $display("[TB] FAIL sb_forward_data got=%h exp=%h", a_rd1, 64'h33); end
        tick;
        a_w = 1'b0;
        #1;
        checks++; if (a_b1 !== 1'b0) begin failures++; $display("[TB] FAIL sb_release_busy got=%b exp=0", a_b1); end
        checks++; if (a_pc !== 6'd0) begin failures++; $display("[TB] FAIL sb_release_count got=%0d exp=0", a_pc); end
        a_rs = 1'b1; a_rsa = 5'd3; a_w = 1'b1; a_wa = 5'd3; a_wd = 64'h34;
        tick;
        a_rs = 1'b0; a_w = 1'b0;
        #1;
        checks++; if (a_b1 !== 1'b1) begin failures++; $display("[TB] FAIL sb_same_busy got=%b exp=1", a_b1); end
        checks++; if (a_pc !== 6'd1) begin failures++; $display("[TB] FAIL sb_same_count got=%0d exp=1", a_pc); end
        checks++; if (a_rd1 !== 64'h34) begin failures++; $display("[TB] FAIL sb_same_data got=%h exp=%h", a_rd1, 64'h34); end
        a_w = 1'b1; a_wa = 5'd3; a_wd = 64'h35;
        tick;
        a_w = 1'b0;
        #1;
        checks++; if (a_pc !== 6'd0) begin failures++; $display("[TB] FAIL sb_clear_count got=%0d exp=0", a_pc); end
    endtask

    task automatic test_back_to_back;
        for (int i = 1; i <= 4; i++) begin
            a_w = 1'b1; a_rs = 1'b1; a_wa = 5'(i); a_rsa = 5'(i);
            a_wd = 64'h1111 * 64'(i);
            tick;
        end
        a_w = 1'b0; a_rs = 1'b0; a_ra1 = 5'd2;
        #1;
        checks++; if (a_pc !== 6'd4) begin failures++; $display("[TB] FAIL b2b_count got=%0d exp=4", a_pc); end
        checks++; if (a_b1 !== 1'b1) begin failures++; $display("[TB] FAIL b2b_busy got=%b exp=1", a_b1); end
        checks++; if (a_rd1 !== 64'h2222) begin failures++; $display("[TB] FAIL b2b_data got=%h exp=%h", a_rd1, 64'h2222); end
        a_rs = 1'b1; a_rsa = 5'd6; a_w = 1'b1; a_wa = 5'd1; a_wd = 64'hAB;
        tick;
        a_rs = 1'b0; a_w = 1'b0; a_ra1 = 5'd6; a_ra2 = 5'd1;
        #1;
        checks++; if (a_pc !== 6'd4) begin failures++; $display("[TB] FAIL diff_count got=%0d exp=4", a_pc); end
        checks++; if (a_b1 !== 1'b1) begin failures++; $display("[TB] FAIL diff_set got=%b exp=1", a_b1); end
        checks++; if (a_b2 !== 1'b0) begin failures++; $display("[TB] FAIL diff_clear got=%b exp=0", a_b2); end
        checks++; if (a_rd2 !== 64'hAB) begin failures++; $display("[TB] FAIL diff_data got=%h exp=%h", a_rd2, 64'hAB); end
        a_rs = 1'b1; a_rsa = 5'd2;
        tick;
        a_rs = 1'b0;
        #1;
        checks++; if (a_pc !== 6'd4) begin failures++; $display("[TB] FAIL rereserve_count got=%0d exp=4", a_pc); end
        #2;
        reset = 1'b1; a_ra1 = 5'd2; a_ra2 = 5'd2;
        a_w = 1'b1; a_wa = 5'd2; a_wd = 64'h77;
        #1;
        checks++; if (a_rd1 !== 64'h0) begin failures++; $display("[TB] FAIL async_rd1 got=%h exp=0", a_rd1); end
        checks++; if (a_rd2 !== 64'h0) begin failures++; $display("[TB] FAIL async_rd2 got=%h exp=0", a_rd2); end
        checks++; if (a_b1 !== 1'b0) begin failures++; $display("[TB] FAIL async_busy got=%b exp=0", a_b1); end
        checks++; if (a_pc !== 6'd0) begin failures++; $display("[TB] FAIL async_count got=%0d exp=0", a_pc); end
        #1;
        a_w = 1'b0;
        tick;
        reset = 1'b0; a_ra1 = 5'd4;
        #1;
        checks++; if (a_rd1 !== 64'h0) begin failures++; $display("[TB] FAIL post_reset_data got=%h exp=0", a_rd1); end
        checks++; if (a_b1 !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_busy got=%b exp=0", a_b1); end
        a_w = 1'b1; a_wa = 5'd4; a_wd = 64'h99; a_rs = 1'b1; a_rsa = 5'd5;
        tick;
        a_w = 1'b0; a_rs = 1'b0; a_ra2 = 5'd5;
        #1;
        checks++; if (a_rd1 !== 64'h99) begin failures++; $display("[TB] FAIL resume_data got=%h exp=%h", a_rd1, 64'h99); end
        checks++; if (a_b2 !== 1'b1) begin failures++; $display("[TB] FAIL resume_busy got=%b exp=1", a_b2); end
        checks++; if (a_pc !== 6'd1) begin failures++; $display("[TB] FAIL resume_count got=%0d exp=1", a_pc); end
    endtask

    task automatic test_small_config;
        c_w = 1'b1; c_wa = 5'd20; c_wd = 32'h12345678;
        c_rs = 1'b1; c_rsa = 5'd20; c_ra1 = 5'd20;
        #1;
        checks++; if (c_rd1 !== 32'h0) begin failures++; $display("[TB] FAIL small_oor_forward got=%h exp=0", c_rd1); end
        tick;
        c_w = 1'b0; c_rs = 1'b0; c_ra2 = 5'd4;
        #1;
        checks++; if (c_rd1 !== 32'h0) begin failures++; $display("[TB] FAIL small_oor_data got=%h exp=0", c_rd1); end
        checks++; if (c_b1 !== 1'b0) begin failures++; $display("[TB] FAIL small_oor_busy got=%b exp=0", c_b1); end
        checks++; if (c_pc !== 6'd0) begin failures++; $display("[TB] FAIL small_oor_count got=%0d exp=0", c_pc); end
        checks++; if (c_rd2 !== 32'h0) begin failures++; $display("[TB] FAIL small_alias got=%h exp=0", c_rd2); end
        c_w = 1'b1; c_wa = 5'd15; c_wd = 32'hCAFE1234;
        c_rs = 1'b1; c_rsa = 5'd15;
        tick;
        c_w = 1'b0; c_rs = 1'b0; c_ra1 = 5'd15;
        #1;
        checks++; if (c_rd1 !== 32'hCAFE1234) begin failures++; $display("[TB] FAIL small_top_data got=%h exp=%h", c_rd1, 32'hCAFE1234); end
        checks++; if (c_b1 !== 1'b1) begin failures++; $display("[TB] FAIL small_top_busy got=%b exp=1", c_b1); end
        checks++; if (c_pc !== 6'd1) begin failures++; $display("[TB] FAIL small_top_count got=%0d exp=1", c_pc); end
    endtask

    // Run every scenario in order, then report
    initial begin
        #2;
        test_reset;
        test_write;
        test_zero_reg;
        test_bypass;
        test_scoreboard;
        test_back_to_back;
        test_small_config;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
